// File: rtl/fru_pla_cfg_loader.sv
// Streams a packed PLA FruSelect configuration frame into a shadow register and commits it atomically.
// Optional FRU_CFG_PARITY_EN adds a CfgParity input; each word then carries even parity over CfgData.
module fru_pla_cfg_loader #(
  parameter int INPUT_SIZE   = 2,
  parameter int OUTPUT_SIZE  = 4,
  parameter int SEGMENT_SIZE = 2,
  parameter int CFG_WIDTH    = 8,
  localparam int MW     = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
  localparam int OW     = 2 ** SEGMENT_SIZE,
  localparam int E      = MW + OW,
  localparam int F      = OUTPUT_SIZE * E,
  localparam int NWORDS = (F + CFG_WIDTH - 1) / CFG_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                CfgValid,
  output logic                                CfgReady,
  input  logic [CFG_WIDTH-1:0]                CfgData,
  input  logic                                CfgLast,
  input  logic                                CfgLock,
  input  logic                                CfgErrClr,
`ifdef FRU_CFG_PARITY_EN
  input  logic                                CfgParity,
`endif
  output logic [OUTPUT_SIZE-1:0][MW-1:0]      RegMux,
  output logic [OUTPUT_SIZE-1:0][OW-1:0]      RegMintermORSelect,
  output logic                                CfgDone,
  output logic                                CfgErr
);

  localparam int CW = $clog2(NWORDS + 1);
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DRAIN} state_t;

  state_t                             state;
  logic [CW-1:0]                      cnt;
  logic [CW-1:0]                      cnt_inc;
  logic [NWORDS-1:0][CFG_WIDTH-1:0]   shadow;
  logic [NWORDS*CFG_WIDTH-1:0]        frame;
  logic                               xfer;
  logic                               par_err;

`ifdef FRU_CFG_PARITY_EN
  assign par_err = (CfgParity != ^CfgData);
`else
  assign par_err = 1'b0;
`endif

  assign CfgReady = (state != COMMIT);
  assign xfer     = CfgValid && CfgReady;
  assign cnt_inc  = cnt + 1'b1;
  assign frame    = shadow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      shadow             <= '0;
      RegMux             <= '0;
      RegMintermORSelect <= '0;
      CfgDone            <= 1'b0;
      CfgErr             <= 1'b0;
    end else begin
      CfgDone <= 1'b0;
      // Clear first so that any error raised below in the same cycle wins.
      if (CfgErrClr) CfgErr <= 1'b0;

      case (state)
        IDLE: begin
          if (xfer) begin
            if (CfgLock || par_err) begin
              CfgErr <= 1'b1;
              state  <= CfgLast ? IDLE : DRAIN;
            end else if (NWORDS == 1) begin
              shadow[0] <= CfgData;
              cnt       <= CW'(1);
              if (CfgLast) begin
                state <= COMMIT;
              end else begin
                CfgErr <= 1'b1;
                state  <= DRAIN;
              end
            end else if (CfgLast) begin
              CfgErr <= 1'b1;
              shadow <= '0;
              cnt    <= '0;
              state  <= IDLE;
            end else begin
              shadow[0] <= CfgData;
              cnt       <= CW'(1);
              state     <= LOAD;
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            if (par_err) begin
              CfgErr <= 1'b1;
              shadow <= '0;
              cnt    <= '0;
              state  <= CfgLast ? IDLE : DRAIN;
            end else if (cnt_inc == CW'(NWORDS)) begin
              shadow[cnt[IW-1:0]] <= CfgData;
              cnt                 <= cnt_inc;
              if (CfgLast) begin
                state <= COMMIT;
              end else begin
                CfgErr <= 1'b1;
                state  <= DRAIN;
              end
            end else if (CfgLast) begin
              CfgErr <= 1'b1;
              shadow <= '0;
              cnt    <= '0;
              state  <= IDLE;
            end else begin
              shadow[cnt[IW-1:0]] <= CfgData;
              cnt                 <= cnt_inc;
            end
          end
        end

        COMMIT: begin
          for (int k = 0; k < OUTPUT_SIZE; k++) begin
            RegMux[k]             <= frame[k*E +: MW];
            RegMintermORSelect[k] <= frame[k*E+MW +: OW];
          end
          CfgDone <= 1'b1;
          cnt     <= '0;
          state   <= IDLE;
        end

        DRAIN: begin
          if (xfer && CfgLast) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fru_pla_cfg_loader.sv
// Directed table-driven bench for fru_pla_cfg_loader at default parameters (NWORDS=3).
module tb_fru_pla_cfg_loader;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [7:0]       cfg_data;
  logic             cfg_last;
  logic             cfg_lock;
  logic             cfg_err_clr;
`ifdef FRU_CFG_PARITY_EN
  logic             cfg_parity;
`endif
  logic [3:0][0:0]  reg_mux;
  logic [3:0][3:0]  reg_mint;
  logic             cfg_done;
  logic             cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fru_pla_cfg_loader dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .CfgValid           (cfg_valid),
    .CfgReady           (cfg_ready),
    .CfgData            (cfg_data),
    .CfgLast            (cfg_last),
    .CfgLock            (cfg_lock),
    .CfgErrClr          (cfg_err_clr),
`ifdef FRU_CFG_PARITY_EN
    .CfgParity          (cfg_parity),
`endif
    .RegMux             (reg_mux),
    .RegMintermORSelect (reg_mint),
    .CfgDone            (cfg_done),
    .CfgErr             (cfg_err)
  );

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [7:0]  dat;
    logic        last;
    logic        lock;
    logic        clr;
    logic        e_rdy;
    logic        e_done;
    logic        e_err;
    logic [3:0]  e_mux;
    logic [15:0] e_mint;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic l, logic lk, logic c,
                              logic rdy, logic dn, logic er, logic [3:0] mx, logic [15:0] mt);
    vec_t t;
    t.rst_n = r; t.vld = v; t.dat = d; t.last = l; t.lock = lk; t.clr = c;
    t.e_rdy = rdy; t.e_done = dn; t.e_err = er; t.e_mux = mx; t.e_mint = mt;
    return t;
  endfunction

  task automatic drive(logic r, logic v, logic [7:0] d, logic l, logic lk, logic c, logic bad_par);
    rst_n       = r;
    cfg_valid   = v;
    cfg_data    = d;
    cfg_last    = l;
    cfg_lock    = lk;
    cfg_err_clr = c;
`ifdef FRU_CFG_PARITY_EN
    cfg_parity  = (^d) ^ bad_par;
`else
    if (bad_par) cfg_lock = lk;
`endif
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  int done_cnt;

  task automatic step(logic v, logic [7:0] d, logic l, logic bad_par);
    drive(1'b1, v, d, l, 1'b0, 1'b0, bad_par);
    @(posedge clk);
    #1;
    if (cfg_done) done_cnt++;
  endtask

  initial begin
    logic [3:0]  got_mux;
    logic [15:0] got_mint;

    // rst vld dat last lock clr | rdy done err mux mint
    tv.push_back(mk(0,0,8'h00,0,0,0, 1,0,0,4'h0,16'h0000)); // reset state
    tv.push_back(mk(1,1,8'h21,0,0,0, 1,0,0,4'h0,16'h0000)); // nominal frame
    tv.push_back(mk(1,1,8'h43,0,0,0, 1,0,0,4'h0,16'h0000));
    tv.push_back(mk(1,1,8'h05,1,0,0, 0,0,0,4'h0,16'h0000)); // COMMIT: not ready, outputs held
    tv.push_back(mk(1,0,8'h00,0,0,0, 1,1,0,4'h3,16'h58C0)); // edge N+1
    tv.push_back(mk(1,0,8'h00,0,0,0, 1,0,0,4'h3,16'h58C0)); // done is one cycle
    tv.push_back(mk(1,1,8'h21,0,0,0, 1,0,0,4'h3,16'h58C0)); // early end
    tv.push_back(mk(1,1,8'h43,1,0,0, 1,0,1,4'h3,16'h58C0));
    tv.push_back(mk(1,0,8'h00,0,0,1, 1,0,0,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'hFF,0,0,0, 1,0,0,4'h3,16'h58C0)); // overlong frame
    tv.push_back(mk(1,1,8'hFF,0,0,0, 1,0,0,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'hFF,0,0,0, 1,0,1,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'hFF,1,0,0, 1,0,1,4'h3,16'h58C0)); // drained
    tv.push_back(mk(1,0,8'h00,0,0,1, 1,0,0,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'h00,0,1,0, 1,0,1,4'h3,16'h58C0)); // locked frame
    tv.push_back(mk(1,1,8'h00,0,0,0, 1,0,1,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'h00,1,0,0, 1,0,1,4'h3,16'h58C0));
    tv.push_back(mk(1,0,8'h00,0,0,1, 1,0,0,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'h00,0,0,0, 1,0,0,4'h3,16'h58C0)); // same frame unlocked
    tv.push_back(mk(1,1,8'h00,0,0,0, 1,0,0,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'h00,1,0,0, 0,0,0,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'h21,0,0,0, 1,1,0,4'h0,16'h0000)); // offered in COMMIT, not taken
    tv.push_back(mk(1,1,8'h21,0,0,0, 1,0,0,4'h0,16'h0000)); // back-to-back frame
    tv.push_back(mk(1,1,8'h43,0,0,0, 1,0,0,4'h0,16'h0000));
    tv.push_back(mk(1,1,8'h05,1,0,0, 0,0,0,4'h0,16'h0000));
    tv.push_back(mk(1,0,8'h00,0,0,0, 1,1,0,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'h00,1,1,0, 1,0,1,4'h3,16'h58C0)); // lock + last -> IDLE
    tv.push_back(mk(1,0,8'h00,0,0,1, 1,0,0,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'h00,1,1,1, 1,0,1,4'h3,16'h58C0)); // set beats clear
    tv.push_back(mk(1,0,8'h00,0,0,1, 1,0,0,4'h3,16'h58C0));
    tv.push_back(mk(1,1,8'hAA,0,0,0, 1,0,0,4'h3,16'h58C0)); // reset mid-frame
    tv.push_back(mk(1,1,8'hAA,0,0,0, 1,0,0,4'h3,16'h58C0));
    tv.push_back(mk(0,0,8'h00,0,0,0, 1,0,0,4'h0,16'h0000));
    tv.push_back(mk(1,1,8'hFF,0,0,0, 1,0,0,4'h0,16'h0000));
    tv.push_back(mk(1,1,8'hFF,0,0,0, 1,0,0,4'h0,16'h0000));
    tv.push_back(mk(1,1,8'h0F,1,0,0, 0,0,0,4'h0,16'h0000));
    tv.push_back(mk(1,0,8'h00,0,0,0, 1,1,0,4'hF,16'hFFFF));
    tv.push_back(mk(1,1,8'h00,1,0,0, 1,0,1,4'hF,16'hFFFF)); // last on first word

    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst_n, tv[i].vld, tv[i].dat, tv[i].last, tv[i].lock, tv[i].clr, 1'b0);
      @(posedge clk);
      #1;
      got_mux  = reg_mux;
      got_mint = reg_mint;
      n_tests++;
      if (cfg_ready !== tv[i].e_rdy || cfg_done !== tv[i].e_done || cfg_err !== tv[i].e_err ||
          got_mux !== tv[i].e_mux || got_mint !== tv[i].e_mint) begin
        n_fail++;
        $display("FAIL vec%0d: got rdy=%b done=%b err=%b mux=%h mint=%h, want rdy=%b done=%b err=%b mux=%h mint=%h",
                 i, cfg_ready, cfg_done, cfg_err, got_mux, got_mint,
                 tv[i].e_rdy, tv[i].e_done, tv[i].e_err, tv[i].e_mux, tv[i].e_mint);
      end
    end

    // Words separated by idle gaps still form one frame and commit exactly once.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    done_cnt = 0;
    step(1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h05, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 1'b0, 1'b0);
    got_mux  = reg_mux;
    got_mint = reg_mint;
    check("gap_done_count", 32'(done_cnt), 32'd1);
    check("gap_mux", 32'(got_mux), 32'h3);
    check("gap_mint", 32'(got_mint), 32'h58C0);
    check("gap_err", 32'(cfg_err), 32'd0);

`ifdef FRU_CFG_PARITY_EN
    // Bad parity on word 2: error, word 3 drained, no commit.
    done_cnt = 0;
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    check("par_err_set", 32'(cfg_err), 32'd1);
    step(1'b1, 8'h0F, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 1'b0, 1'b0);
    got_mux  = reg_mux;
    got_mint = reg_mint;
    check("par_no_done", 32'(done_cnt), 32'd0);
    check("par_mux_held", 32'(got_mux), 32'h3);
    check("par_mint_held", 32'(got_mint), 32'h58C0);
    check("par_err_sticky", 32'(cfg_err), 32'd1);
    check("par_rdy_idle", 32'(cfg_ready), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fru_pla_cfg_loader.md
FRU_PLA_CFG_LOADER -- requirements
Module: fru_pla_cfg_loader

Interface
REQ-001 Parameter INPUT_SIZE, default 2: trigger count of the downstream PLA; mux field width MW = $clog2(INPUT_SIZE).
REQ-002 Parameter OUTPUT_SIZE, default 4: number of FruSelect outputs configured.
REQ-003 Parameter SEGMENT_SIZE, default 2: minterm-select field width OW = 2**SEGMENT_SIZE.
REQ-004 Parameter CFG_WIDTH, default 8: config word width.
REQ-005 Derived constants: entry width E = MW+OW; frame width F = OUTPUT_SIZE*E; NWORDS = ceil(F/CFG_WIDTH).
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 CfgValid  in  1  config word valid.
REQ-009 CfgReady  out  1  loader accepts a word; a transfer occurs when CfgValid && CfgReady.
REQ-010 CfgData  in  CFG_WIDTH  config word.
REQ-011 CfgLast  in  1  marks the final word of a frame.
REQ-012 CfgLock  in  1  when high at the first word of a frame, the frame is rejected.
REQ-013 CfgErrClr  in  1  clears CfgErr.
REQ-014 RegMux  out  [OUTPUT_SIZE-1:0][MW-1:0]  active mux configuration.
REQ-015 RegMintermORSelect  out  [OUTPUT_SIZE-1:0][OW-1:0]  active minterm-OR configuration.
REQ-016 CfgDone  out  1  one-cycle pulse when a frame is committed.
REQ-017 CfgErr  out  1  sticky frame-error flag.

Function
REQ-018 Frame packing: word i supplies frame bits [i*CFG_WIDTH +: CFG_WIDTH], LSB first; bits at or above F are ignored.
REQ-019 Entry packing: entry k = frame bits [k*E +: E]; RegMux[k] = the low MW bits of the entry; RegMintermORSelect[k] = the high OW bits.
REQ-020 States: IDLE, LOAD, COMMIT, DRAIN.
REQ-021 CfgReady is 1 in IDLE, LOAD and DRAIN, and 0 in COMMIT.
REQ-022 Accepted words are written into a shadow register; active outputs do not change before commit.
REQ-023 IDLE: the first accepted word resets the word counter to 1 and enters LOAD. If NWORDS==1 and CfgLast is set, it enters COMMIT instead.
REQ-024 LOAD: each accepted word increments the counter. The word that makes the count equal NWORDS moves the FSM to COMMIT if CfgLast=1; otherwise it sets CfgErr and moves to DRAIN.
REQ-025 Early end: CfgLast on a word with count < NWORDS sets CfgErr, discards the shadow and returns to IDLE.
REQ-026 COMMIT lasts exactly one cycle; at its ending edge the shadow is copied to the active outputs, CfgDone is high for the following cycle, and the FSM returns to IDLE.
REQ-027 Latency: the last word is accepted at edge N; outputs and CfgDone update at edge N+1.
REQ-028 DRAIN: accepts and discards words until a word with CfgLast, then returns to IDLE; no commit.
REQ-029 Lock: CfgLock=1 on the first word of a frame sets CfgErr and sends the FSM to DRAIN, or to IDLE if that word has CfgLast; the active outputs are untouched.
REQ-030 CfgErr clears on CfgErrClr; a new error in the same cycle wins (flag stays 1).
REQ-031 Back-to-back: a word offered in the cycle after COMMIT is accepted in IDLE; no bubble other than the COMMIT cycle.

Reset
REQ-032 While rst_n=0 at an edge: FSM=IDLE, counter=0, shadow=0, RegMux=0, RegMintermORSelect=0 (all FruSelect inactive), CfgDone=0, CfgErr=0.
REQ-033 Reset mid-frame discards the partial frame; the next accepted word is treated as a frame start.

Configuration
REQ-034 Macro FRU_CFG_PARITY_EN: when defined, a port CfgParity in 1 is added, carrying even parity over CfgData.
REQ-035 With FRU_CFG_PARITY_EN, a mismatching word is treated as a frame error: CfgErr is set, and the FSM goes to IDLE if that word has CfgLast, else to DRAIN.
REQ-036 Without FRU_CFG_PARITY_EN, no parity port exists and there is no parity checking.

Verification (INPUT_SIZE=2, OUTPUT_SIZE=4, SEGMENT_SIZE=2, CFG_WIDTH=8: E=5, F=20, NWORDS=3)
REQ-037 Words 0x21, 0x43, 0x05 (last) -> at edge N+1: RegMux={0,0,1,1} for [3..0], RegMintermORSelect={0x5,0x8,0xC,0x0}, CfgDone pulses once, CfgErr=0.
REQ-038 Words 0x21, 0x43 (last on second word) -> CfgErr=1, outputs unchanged, FSM in IDLE.
REQ-039 Four words with CfgLast only on the 4th -> CfgErr set on the 3rd word; the 4th word is drained; no CfgDone; outputs unchanged.
REQ-040 CfgLock=1 with a valid 3-word frame -> CfgErr=1, no commit; CfgErrClr then clears the flag, and the same frame with CfgLock=0 commits.
REQ-041 rst_n=0 after the 2nd word, then a full 3-word frame -> commits with the new frame's values only.
REQ-042 With FRU_CFG_PARITY_EN defined, a bad parity bit on word 2 -> CfgErr=1, word 3 is drained, no commit.
